curve_ladder_sequencer: RTL and testbench
=========================================

// Module: curve_ladder_sequencer
// PURPOSE
//  Control/scheduling front end of the Curve25519 peripheral, between the I2C slave register port and the
//  ladder datapath. Holds the 32-byte scalar, decodes control/status registers and forwards point/result bytes.
//  Sequences the Montgomery ladder: clamps the scalar, issues 255 step requests with cswap bits, then the
//  final swap + inversion request. Raises the done interrupt.
// PARAMETERS
//  NSTEPS   255   ladder iterations; bit index runs NSTEPS-1 .. 0
//  TIMEOUT  4096  max cycles waiting on any datapath ack before ERROR
// PORTS
//  clk        in   1  single clock, all logic rising-edge
//  reset      in   1  synchronous, active-high
//  subaddr    in   8  I2C register address
//  wr_data    in   8  I2C write byte
//  wr_pulse   in   1  1-cycle write strobe
//  rd_pulse   in   1  1-cycle read strobe (read-to-clear side effects)
//  rd_data    out  8  registered read byte for subaddr
//  step_start out  1  1-cycle ladder-step request
//  step_swap  out  1  cswap bit for this step, valid with step_start
//  step_done  in   1  1-cycle step completion
//  inv_start  out  1  1-cycle final-swap+inversion request
//  inv_swap   out  1  final cswap bit, valid with inv_start
//  inv_done   in   1  1-cycle inversion completion
//  dp_we      out  1  byte write to datapath point RAM
//  dp_addr    out  6  datapath byte address (0x00-0x1F point u, 0x20-0x3F result)
//  dp_wdata   out  8  datapath write byte
//  dp_rdata   in   8  datapath read byte, combinational on dp_addr
//  busy       out  1  high in any state other than IDLE/DONE/ERROR
//  done       out  1  interrupt: status.done & ctrl.ie
// BEHAVIOUR
//  Reset: all outputs 0, scalar 0, ctrl 0, status 0, FSM IDLE, swap 0, idx NSTEPS-1, timer 0.
//  Map: 0x00-0x1F scalar (LE byte 0 = bits 7:0); 0x20-0x3F point u -> dp addr 0x00-0x1F;
//   0x40 CTRL {ie[2],abort[1],start[0]}; start/abort self-clear, read back 0; 0x41 STATUS {err[3],wr_err[2],
//   aborted[1],done[0]}; 0x42 IDX (current bit index, 7:0); 0x60-0x7F result <- dp addr 0x20-0x3F; others read 0.
//  rd_data registered every cycle from subaddr (1-cycle latency). rd_pulse at 0x41 clears done/aborted/wr_err/err
//   on the next edge; the read value is the pre-clear value.
//  Writes to scalar or 0x20-0x3F while busy are dropped and set wr_err; dp_we=0 on drop. Non-dropped writes to
//   0x20-0x3F drive dp_we/dp_addr/dp_wdata combinationally in the wr_pulse cycle.
//  FSM: IDLE -start-> LOAD (1 cycle: clamp scalar: bits 2:0=0, bit255=0, bit254=1; idx=NSTEPS-1; swap=0; clear done)
//   -> STEP_REQ (step_start=1, step_swap=swap^k[idx], swap<=k[idx]) -> STEP_WAIT.
//   STEP_WAIT on step_done: idx==0 -> INV_REQ, else idx-1 -> STEP_REQ.
//   INV_REQ (inv_start=1, inv_swap=swap) -> INV_WAIT -inv_done-> DONE (set status.done).
//   DONE/ERROR accept start (-> LOAD), like IDLE.
//  Latency: LOAD + per step (1 + ack delay) + 1 + inv ack delay; with 1-cycle acks, start-write->done = 2+2*NSTEPS+2.
//  Timer restarts on entering each *_WAIT; reaching TIMEOUT -> ERROR, set err, busy=0.
//  Abort (write CTRL bit1) in any busy state: next state IDLE, set aborted, late step_done/inv_done ignored.
//   Abort+start in one write: abort wins. Start while busy: ignored.
//  step_done/inv_done outside the matching WAIT state: ignored. Done and ack in the same cycle as abort: abort wins.
//  Reset mid-operation: returns to IDLE next edge; no further requests.
// STRUCTURE
//  Shared package curve_periph_pkg: register address constants, CTRL/STATUS bit positions, FSM state enum.
//  One sub-module: curve_regfile (scalar storage, address decode, rd_data mux, status flags); FSM and timer here.
// TESTING
//  1 Write scalar 0xFF x32, start, 1-cycle acks -> 255 step_start, idx 254..0, done after 514 cycles, clamped k[255]=0, k[2:0]=0.
//  2 Scalar 0x00.., start -> first step_swap=1 (k254=1), rest 0; inv_swap=0; STATUS reads 0x01 then 0x00.
//  3 Abort at step 100 -> busy drops next cycle, STATUS=0x02, late step_done causes no step_start.
//  4 Withhold step_done -> ERROR after TIMEOUT cycles, STATUS bit3 set, start recovers.
//  5 Write 0x05 to 0x00 while busy -> scalar unchanged, STATUS bit2 set; write 0xAB to 0x25 idle -> dp_we, addr 0x05, data 0xAB.
//  6 ie=0 -> done pin stays 0 with status.done=1; set ie -> done high; reset mid-ladder -> all outputs 0.

Source files
------------

// File: rtl/curve_periph_pkg.sv
// Shared definitions for the Curve25519 peripheral: register map, CTRL/STATUS
// bit positions and the ladder sequencer state encoding.
package curve_periph_pkg;

    localparam int DEF_NSTEPS  = 255;
    localparam int DEF_TIMEOUT = 4096;

    localparam logic [7:0] A_CTRL   = 8'h40;
    localparam logic [7:0] A_STATUS = 8'h41;
    localparam logic [7:0] A_IDX    = 8'h42;

    localparam int C_START = 0;
    localparam int C_ABORT = 1;
    localparam int C_IE    = 2;

    localparam int S_DONE    = 0;
    localparam int S_ABORTED = 1;
    localparam int S_WRERR   = 2;
    localparam int S_ERR     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP_REQ,
        ST_STEP_WAIT,
        ST_INV_REQ,
        ST_INV_WAIT,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

endpackage

// File: rtl/curve_ladder_sequencer_if.sv
// Register-port and datapath handshake bundle of the ladder sequencer.
interface curve_ladder_sequencer_if;
    logic [7:0] subaddr;
    logic [7:0] wr_data;
    logic       wr_pulse;
    logic       rd_pulse;
    logic [7:0] rd_data;
    logic       step_start;
    logic       step_swap;
    logic       step_done;
    logic       inv_start;
    logic       inv_swap;
    logic       inv_done;
    logic       dp_we;
    logic [5:0] dp_addr;
    logic [7:0] dp_wdata;
    logic [7:0] dp_rdata;
    logic       busy;
    logic       done;

    // Sequencer side
    modport slave (
        input  subaddr, wr_data, wr_pulse, rd_pulse, step_done, inv_done, dp_rdata,
        output rd_data, step_start, step_swap, inv_start, inv_swap,
               dp_we, dp_addr, dp_wdata, busy, done
    );

    // Host / datapath side
    modport master (
        output subaddr, wr_data, wr_pulse, rd_pulse, step_done, inv_done, dp_rdata,
        input  rd_data, step_start, step_swap, inv_start, inv_swap,
               dp_we, dp_addr, dp_wdata, busy, done
    );
endinterface

// File: rtl/curve_regfile.sv
// Scalar storage, register decode, registered read mux and sticky status flags.
module curve_regfile
    import curve_periph_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_subaddr,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_pulse,
    input  logic       i_rd_pulse,
    input  logic [7:0] i_dp_rdata,
    input  logic       i_busy,
    input  logic       i_load,
    input  logic       i_set_done,
    input  logic       i_set_err,
    input  logic       i_set_aborted,
    input  logic [7:0] i_idx,
    output logic [7:0] o_rd_data,
    output logic       o_k_bit,
    output logic       o_start,
    output logic       o_abort,
    output logic       o_irq,
    output logic       o_dp_we,
    output logic [5:0] o_dp_addr,
    output logic [7:0] o_dp_wdata
);
    logic [255:0] r_scalar;
    logic         r_ie;
    logic [3:0]   r_status;
    logic [7:0]   r_rd_data;

    logic       w_scalar_sel, w_point_sel, w_result_sel, w_ctrl_wr, w_drop, w_stat_clr;
    logic [7:0] w_rd_next;

    assign w_scalar_sel = (i_subaddr[7:5] == 3'b000);
    assign w_point_sel  = (i_subaddr[7:5] == 3'b001);
    assign w_result_sel = (i_subaddr[7:5] == 3'b011);
    assign w_ctrl_wr    = i_wr_pulse && (i_subaddr == A_CTRL);
    assign w_drop       = i_wr_pulse && i_busy && (w_scalar_sel || w_point_sel);
    assign w_stat_clr   = i_rd_pulse && (i_subaddr == A_STATUS);

    // Abort takes precedence over a start carried in the same CTRL write
    assign o_start    = w_ctrl_wr && i_wr_data[C_START] && !i_wr_data[C_ABORT];
    assign o_abort    = w_ctrl_wr && i_wr_data[C_ABORT];
    assign o_irq      = r_status[S_DONE] && r_ie;
    assign o_k_bit    = r_scalar[i_idx];
    assign o_dp_we    = i_wr_pulse && w_point_sel && !i_busy;
    assign o_dp_addr  = (w_point_sel || w_result_sel) ? {i_subaddr[6], i_subaddr[4:0]} : 6'h00;
    assign o_dp_wdata = o_dp_we ? i_wr_data : 8'h00;
    assign o_rd_data  = r_rd_data;

    always_comb begin
        w_rd_next = 8'h00;
        if (w_scalar_sel)                     w_rd_next = r_scalar[{i_subaddr[4:0], 3'b000} +: 8];
        else if (w_point_sel || w_result_sel) w_rd_next = i_dp_rdata;
        else if (i_subaddr == A_CTRL)         w_rd_next = {5'b0, r_ie, 2'b00};
        else if (i_subaddr == A_STATUS)       w_rd_next = {4'b0, r_status};
        else if (i_subaddr == A_IDX)          w_rd_next = i_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scalar  <= '0;
            r_ie      <= 1'b0;
            r_status  <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_next;
            if (i_load) begin
                r_scalar[2:0] <= 3'b000;
                r_scalar[255] <= 1'b0;
                r_scalar[254] <= 1'b1;
            end else if (i_wr_pulse && w_scalar_sel && !i_busy) begin
                r_scalar[{i_subaddr[4:0], 3'b000} +: 8] <= i_wr_data;
            end
            if (w_ctrl_wr) r_ie <= i_wr_data[C_IE];
            // Read-to-clear first so that an event landing in the same cycle is kept
            if (w_stat_clr)    r_status           <= '0;
            if (i_load)        r_status[S_DONE]    <= 1'b0;
            if (i_set_done)    r_status[S_DONE]    <= 1'b1;
            if (i_set_aborted) r_status[S_ABORTED] <= 1'b1;
            if (w_drop)        r_status[S_WRERR]   <= 1'b1;
            if (i_set_err)     r_status[S_ERR]     <= 1'b1;
        end
    end
endmodule

// File: rtl/curve_ladder_sequencer.sv
// Montgomery ladder scheduler: clamps the scalar, issues NSTEPS cswap step
// requests MSB-first, then the final swap + inversion, with an ack watchdog.
module curve_ladder_sequencer
    import curve_periph_pkg::*;
#(
    parameter int NSTEPS  = DEF_NSTEPS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                      clk,
    input logic                      reset,
    curve_ladder_sequencer_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_e    r_state, w_state_nxt;
    logic [7:0]    r_idx;
    logic          r_swap;
    logic [TW-1:0] r_timer;

    logic w_k_bit, w_start, w_abort, w_busy, w_load, w_set_done, w_set_err, w_timeout;

    curve_regfile u_regfile (
        .clk          (clk),
        .reset        (reset),
        .i_subaddr    (bus.subaddr),
        .i_wr_data    (bus.wr_data),
        .i_wr_pulse   (bus.wr_pulse),
        .i_rd_pulse   (bus.rd_pulse),
        .i_dp_rdata   (bus.dp_rdata),
        .i_busy       (w_busy),
        .i_load       (w_load),
        .i_set_done   (w_set_done),
        .i_set_err    (w_set_err),
        .i_set_aborted(w_abort && w_busy),
        .i_idx        (r_idx),
        .o_rd_data    (bus.rd_data),
        .o_k_bit      (w_k_bit),
        .o_start      (w_start),
        .o_abort      (w_abort),
        .o_irq        (bus.done),
        .o_dp_we      (bus.dp_we),
        .o_dp_addr    (bus.dp_addr),
        .o_dp_wdata   (bus.dp_wdata)
    );

    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));
    assign bus.busy  = w_busy;

    always_comb begin
        w_state_nxt    = r_state;
        w_busy         = 1'b1;
        w_load         = 1'b0;
        w_set_done     = 1'b0;
        w_set_err      = 1'b0;
        bus.step_start = 1'b0;
        bus.step_swap  = 1'b0;
        bus.inv_start  = 1'b0;
        bus.inv_swap   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                w_busy = 1'b0;
                if (w_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_STEP_REQ;
            end
            ST_STEP_REQ: begin
                bus.step_start = 1'b1;
                bus.step_swap  = r_swap ^ w_k_bit;
                w_state_nxt    = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
                if (bus.step_done) begin
                    w_state_nxt = (r_idx == 8'd0) ? ST_INV_REQ : ST_STEP_REQ;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERROR;
                    w_set_err   = 1'b1;
                end
            end
            ST_INV_REQ: begin
                bus.inv_start = 1'b1;
                bus.inv_swap  = r_swap;
                w_state_nxt   = ST_INV_WAIT;
            end
            ST_INV_WAIT: begin
                if (bus.inv_done) begin
                    w_state_nxt = ST_DONE;
                    w_set_done  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERROR;
                    w_set_err   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Abort overrides any ack, timeout or request in the same cycle
        if (w_abort && w_busy) begin
            w_state_nxt    = ST_IDLE;
            w_set_done     = 1'b0;
            w_set_err      = 1'b0;
            bus.step_start = 1'b0;
            bus.step_swap  = 1'b0;
            bus.inv_start  = 1'b0;
            bus.inv_swap   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= 8'(NSTEPS - 1);
            r_swap  <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= (r_state == ST_STEP_WAIT || r_state == ST_INV_WAIT) ? r_timer + 1'b1 : '0;
            if (w_load) begin
                r_idx  <= 8'(NSTEPS - 1);
                r_swap <= 1'b0;
            end
            if (r_state == ST_STEP_REQ) r_swap <= w_k_bit;
            if (r_state == ST_STEP_WAIT && w_state_nxt == ST_STEP_REQ) r_idx <= r_idx - 8'd1;
        end
    end
endmodule

// File: tb/tb_curve_ladder_sequencer.sv
// Directed bench for the ladder sequencer with a modelled step/inversion datapath.
module tb_curve_ladder_sequencer;
    import curve_periph_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    curve_ladder_sequencer_if bus();

    curve_ladder_sequencer #(.NSTEPS(255), .TIMEOUT(4096)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Datapath RAM model: each byte reads back as 0x80 | address
    assign bus.dp_rdata = {2'b10, bus.dp_addr};

    logic [28:0] outs;
    assign outs = {bus.step_start, bus.step_swap, bus.inv_start, bus.inv_swap, bus.busy,
                   bus.done, bus.rd_data, bus.dp_we, bus.dp_addr, bus.dp_wdata};

    int   total = 0;
    int   bad   = 0;
    int   n_steps = 0;
    int   n_inv   = 0;
    logic inv_seen = 1'b0;
    logic ack_en   = 1'b1;
    logic late_ack = 1'b0;
    logic       sw_log  [0:4095];
    logic [7:0] idx_log [0:4095];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ack responder: samples requests on the falling edge, acks one cycle later
    initial begin
        logic s_pend, i_pend, prev_ss;
        s_pend = 0; i_pend = 0; prev_ss = 0;
        bus.step_done = 1'b0;
        bus.inv_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ss && n_steps > 0) idx_log[n_steps-1] = bus.rd_data;
            prev_ss = bus.step_start;
            if (bus.step_start) begin
                sw_log[n_steps] = bus.step_swap;
                n_steps++;
                if (ack_en) s_pend = 1'b1;
            end
            if (bus.inv_start) begin
                inv_seen = bus.inv_swap;
                n_inv++;
                if (ack_en) i_pend = 1'b1;
            end
            @(posedge clk); #1;
            bus.step_done = s_pend | late_ack;
            bus.inv_done  = i_pend;
            s_pend = 1'b0;
            i_pend = 1'b0;
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.subaddr = a; bus.wr_data = d; bus.wr_pulse = 1'b1;
        @(posedge clk); #1;
        bus.wr_pulse = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic pulse, output logic [7:0] d);
        @(posedge clk); #1;
        bus.subaddr = a; bus.rd_pulse = pulse;
        @(posedge clk); #1;
        bus.rd_pulse = 1'b0;
        d = bus.rd_data;
    endtask

    // Cycles counted from the start-write cycle (= 0) to the first idle cycle
    task automatic wait_idle(output int cyc);
        cyc = 1;
        while (bus.busy && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_steps(input int target);
        int t;
        t = 0;
        while (n_steps < target && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_steps_timeout", (t < 2000), 1);
    endtask

    task automatic chk_run(input string tag, input int base, input logic [255:0] s, input bit do_idx);
        logic [255:0] k;
        logic sw, e;
        int nb;
        k = s; k[2:0] = 3'b000; k[255] = 1'b0; k[254] = 1'b1;
        sw = 1'b0; nb = 0;
        for (int i = 254; i >= 0; i--) begin
            e  = sw ^ k[i];
            sw = k[i];
            if (sw_log[base+254-i] !== e) nb++;
            if (do_idx && idx_log[base+254-i] !== 8'(i)) nb++;
        end
        chk({tag, "_swaps"}, nb, 0);
        chk({tag, "_inv_swap"}, inv_seen, sw);
    endtask

    initial begin
        logic [7:0] d;
        int cyc, base, ninv0, nsnap;
        bus.subaddr = 8'h00; bus.wr_data = 8'h00; bus.wr_pulse = 1'b0; bus.rd_pulse = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", outs, 0);
        reset = 1'b0;
        rd(A_IDX, 1'b0, d);    chk("rst_idx", d, 8'hFE);
        rd(A_STATUS, 1'b0, d); chk("rst_status", d, 8'h00);
        rd(A_CTRL, 1'b0, d);   chk("rst_ctrl", d, 8'h00);

        // 1: all-ones scalar, full ladder with single-cycle acks
        for (int i = 0; i < 32; i++) wr(8'(i), 8'hFF);
        base = n_steps; ninv0 = n_inv;
        wr(A_CTRL, 8'h05);
        bus.subaddr = A_IDX;
        wait_idle(cyc);
        chk("t1_latency", cyc, 514);
        chk("t1_done_pin", bus.done, 1);
        chk("t1_nsteps", n_steps - base, 255);
        chk("t1_ninv", n_inv - ninv0, 1);
        chk_run("t1", base, {256{1'b1}}, 1'b1);
        rd(8'h1F, 1'b0, d);    chk("t1_k_top", d, 8'h7F);
        rd(8'h00, 1'b0, d);    chk("t1_k_low", d, 8'hF8);
        rd(8'h10, 1'b0, d);    chk("t1_k_mid", d, 8'hFF);
        rd(A_IDX, 1'b0, d);    chk("t1_idx_end", d, 8'h00);
        rd(A_CTRL, 1'b0, d);   chk("t1_ctrl_rb", d, 8'h04);
        rd(8'h65, 1'b0, d);    chk("t1_result", d, 8'hA5);
        rd(A_STATUS, 1'b1, d); chk("t1_status", d, 8'h01);

        // 2: zero scalar, only the clamped bit 254 is set
        for (int i = 0; i < 32; i++) wr(8'(i), 8'h00);
        base = n_steps;
        wr(A_CTRL, 8'h05);
        bus.subaddr = A_IDX;
        wait_idle(cyc);
        chk("t2_latency", cyc, 514);
        chk("t2_first_swap", sw_log[base], 1);
        chk_run("t2", base, 256'd0, 1'b1);
        rd(A_STATUS, 1'b1, d); chk("t2_status_pre", d, 8'h01);
        rd(A_STATUS, 1'b0, d); chk("t2_status_post", d, 8'h00);

        // 3: abort at step 100, then a stray ack
        base = n_steps;
        wr(A_CTRL, 8'h05);
        wait_steps(base + 100);
        wr(A_CTRL, 8'h06);
        chk("t3_busy_drop", bus.busy, 0);
        nsnap = n_steps;
        #2 late_ack = 1'b1;
        @(posedge clk); #3 late_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_late_ack", n_steps - nsnap, 0);
        chk("t3_still_idle", bus.busy, 0);
        rd(A_STATUS, 1'b1, d); chk("t3_status", d, 8'h02);

        // 4: withheld step ack trips the watchdog, then start recovers
        ack_en = 1'b0;
        wr(A_CTRL, 8'h05);
        wait_idle(cyc);
        chk("t4_timeout_cyc", cyc, 3 + 4096);
        rd(A_STATUS, 1'b1, d); chk("t4_status", d, 8'h08);
        ack_en = 1'b1;
        base = n_steps;
        wr(A_CTRL, 8'h05);
        wait_idle(cyc);
        chk("t4_recover_cyc", cyc, 514);
        chk("t4_recover_done", bus.done, 1);

        // 5: writes while busy are dropped; idle point write reaches the datapath
        wr(8'h00, 8'h33);
        wr(A_CTRL, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        bus.subaddr = 8'h00; bus.wr_data = 8'h05; bus.wr_pulse = 1'b1;
        #1 chk("t5_drop_scalar_we", bus.dp_we, 0);
        @(posedge clk); #1;
        bus.subaddr = 8'h25; bus.wr_data = 8'hAB;
        #1 chk("t5_drop_point_we", bus.dp_we, 0);
        @(posedge clk); #1;
        bus.wr_pulse = 1'b0;
        wr(A_CTRL, 8'h06);
        rd(8'h00, 1'b0, d);    chk("t5_scalar_kept", d, 8'h30);
        rd(A_STATUS, 1'b1, d); chk("t5_status", d, 8'h06);
        @(posedge clk); #1;
        bus.subaddr = 8'h25; bus.wr_data = 8'hAB; bus.wr_pulse = 1'b1;
        #1;
        chk("t5_we", bus.dp_we, 1);
        chk("t5_addr", bus.dp_addr, 6'h05);
        chk("t5_wdata", bus.dp_wdata, 8'hAB);
        @(posedge clk); #1;
        bus.wr_pulse = 1'b0;
        #1 chk("t5_we_low", bus.dp_we, 0);

        // 6: interrupt enable gating, then reset mid-ladder
        wr(A_CTRL, 8'h01);
        wait_idle(cyc);
        chk("t6_done_masked", bus.done, 0);
        wr(A_CTRL, 8'h04);
        chk("t6_done_unmasked", bus.done, 1);
        rd(A_STATUS, 1'b1, d); chk("t6_status", d, 8'h01);
        chk("t6_done_cleared", bus.done, 0);
        base = n_steps;
        wr(A_CTRL, 8'h05);
        bus.subaddr = A_IDX;
        wait_steps(base + 50);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_outs", outs, 0);
        reset = 1'b0;
        nsnap = n_steps;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_steps", n_steps - nsnap, 0);
        chk("t6_idle", bus.busy, 0);
        rd(A_IDX, 1'b0, d); chk("t6_idx_reset", d, 8'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
